// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage: a main register drives the outputs and a skid slot
// takes one extra beat so in_ready never depends on out_ready combinationally.
module pipe_skid_reg #(
  parameter int unsigned        PC_W     = 32,
  parameter int unsigned        INST_W   = 32,
  parameter int unsigned        SIDE_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h00000013,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [SIDE_W-1:0] out_side,
  output logic [1:0]        occupancy,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        state;
  logic [PC_W-1:0]   main_pc,   skid_pc;
  logic [INST_W-1:0] main_inst, skid_inst;
  logic [SIDE_W-1:0] main_side, skid_side;
  logic              in_acc, out_acc;

  // The state encoding doubles as the entry count.
  assign occupancy = state;
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_pc    = main_pc;
  assign out_inst  = main_inst;
  assign out_side  = main_side;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      main_pc   <= '0;
      main_inst <= NOP_INST;
      main_side <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
      skid_side <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      main_pc   <= '0;
      main_inst <= NOP_INST;
      main_side <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
      skid_side <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_acc) begin
            state     <= ONE;
            main_pc   <= in_pc;
            main_inst <= in_inst;
            main_side <= in_side;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            main_pc   <= in_pc;
            main_inst <= in_inst;
            main_side <= in_side;
          end else if (in_acc) begin
            state     <= FULL;
            skid_pc   <= in_pc;
            skid_inst <= in_inst;
            skid_side <= in_side;
          end else if (out_acc) begin
            // Main returns to the idle payload so an empty stage shows a NOP.
            state     <= EMPTY;
            main_pc   <= '0;
            main_inst <= NOP_INST;
            main_side <= '0;
          end
        end
        FULL: begin
          if (out_acc) begin
            state     <= ONE;
            main_pc   <= skid_pc;
            main_inst <= skid_inst;
            main_side <= skid_side;
          end
        end
        default: begin
          state     <= EMPTY;
          main_pc   <= '0;
          main_inst <= NOP_INST;
          main_side <= '0;
        end
      endcase
    end
  end

  // Stall counter ignores flush; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, push/drain ordering, flush, streaming
// and stall counter saturation, with a 4-bit counter to reach saturation quickly.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [31:0] in_side;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] out_side;
  logic [1:0]  occupancy;
  logic        stall_clr;
  logic [3:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_skid_reg #(
    .PC_W(32), .INST_W(32), .SIDE_W(32),
    .NOP_INST(32'h00000013), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_side(out_side),
    .occupancy(occupancy), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the inputs, then advance one rising edge and settle 1 time unit past it.
  task automatic apply_stimulus(input logic r, input logic fl, input logic iv,
                                input logic [31:0] pc, input logic [31:0] inst,
                                input logic [31:0] side, input logic ordy,
                                input logic sclr);
    rst = r; flush = fl; in_valid = iv; in_pc = pc; in_inst = inst;
    in_side = side; out_ready = ordy; stall_clr = sclr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    in_side = '0; out_ready = 1'b0; stall_clr = 1'b0;
    #2;

    // Reset values
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("rst_occ", occupancy, 0);
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_inst", out_inst, 32'h13);
    check_output("rst_out_pc", out_pc, 0);
    check_output("rst_stall", stall_cnt, 0);

    // Leaving reset does not create a beat
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0);
    check_output("idle_out_valid", out_valid, 0);

    // Single beat, one-cycle latency
    apply_stimulus(1, 0, 1, 32'h100, 32'h00500093, 32'hAAAA, 1, 0);
    check_output("first_valid", out_valid, 1);
    check_output("first_pc", out_pc, 32'h100);
    check_output("first_inst", out_inst, 32'h00500093);
    check_output("first_side", out_side, 32'hAAAA);
    check_output("first_occ", occupancy, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0);
    check_output("drain_occ", occupancy, 0);
    check_output("drain_inst", out_inst, 32'h13);
    check_output("drain_pc", out_pc, 0);
    check_output("drain_side", out_side, 0);

    // Fill to FULL with downstream blocked, then drain in order
    apply_stimulus(1, 0, 1, 32'h200, 32'h11, 32'h1, 0, 0);
    check_output("fill1_occ", occupancy, 1);
    apply_stimulus(1, 0, 1, 32'h204, 32'h22, 32'h2, 0, 0);
    check_output("fill2_occ", occupancy, 2);
    check_output("fill2_in_ready", in_ready, 0);
    check_output("fill2_pc", out_pc, 32'h200);
    check_output("fill2_stall", stall_cnt, 1);
    apply_stimulus(1, 0, 1, 32'h208, 32'h33, 32'h3, 0, 0);
    check_output("full_hold_occ", occupancy, 2);
    check_output("full_hold_pc", out_pc, 32'h200);
    check_output("full_hold_stall", stall_cnt, 2);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0);
    check_output("pop1_pc", out_pc, 32'h204);
    check_output("pop1_inst", out_inst, 32'h22);
    check_output("pop1_side", out_side, 32'h2);
    check_output("pop1_occ", occupancy, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0);
    check_output("pop2_occ", occupancy, 0);
    check_output("pop2_valid", out_valid, 0);
    check_output("pop2_stall", stall_cnt, 2);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1);
    check_output("clr_stall", stall_cnt, 0);

    // Flush while FULL discards everything, including the incoming beat
    apply_stimulus(1, 0, 1, 32'h280, 32'h44, 32'h4, 0, 0);
    apply_stimulus(1, 0, 1, 32'h284, 32'h55, 32'h5, 0, 0);
    check_output("pre_flush_occ", occupancy, 2);
    apply_stimulus(1, 1, 1, 32'h300, 32'h66, 32'h6, 0, 0);
    check_output("flush_occ", occupancy, 0);
    check_output("flush_valid", out_valid, 0);
    check_output("flush_inst", out_inst, 32'h13);
    check_output("flush_pc", out_pc, 0);
    check_output("flush_stall", stall_cnt, 2);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0);
    check_output("post_flush_valid", out_valid, 0);
    check_output("post_flush_pc", out_pc, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1);
    check_output("flush_clr_stall", stall_cnt, 0);

    // Streaming: one beat per cycle, pcs 0x0..0x1C
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1, 0, 1, 32'(i * 4), 32'(32'h1000 + i), 32'(i), 1, 0);
      check_output($sformatf("stream_pc%0d", i), out_pc, 64'(i * 4));
      check_output($sformatf("stream_inst%0d", i), out_inst, 64'(32'h1000 + i));
      check_output($sformatf("stream_rdy%0d", i), in_ready, 1);
    end
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0);
    check_output("stream_end_occ", occupancy, 0);
    check_output("stream_stall", stall_cnt, 0);

    // Stall counter saturates at 15 with a 4-bit width
    apply_stimulus(1, 0, 1, 32'h3F0, 32'h77, 32'h7, 0, 0);
    check_output("sat_start", stall_cnt, 0);
    for (int k = 1; k <= 20; k++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
      if (k == 3) check_output("sat_mid", stall_cnt, 3);
    end
    check_output("sat_end", stall_cnt, 15);
    check_output("sat_pc", out_pc, 32'h3F0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1);
    check_output("sat_clr", stall_cnt, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    check_output("sat_restart", stall_cnt, 1);

    // Reset while FULL with downstream ready
    apply_stimulus(1, 0, 1, 32'h400, 32'h88, 32'h8, 0, 0);
    check_output("pre_rst_occ", occupancy, 2);
    apply_stimulus(0, 1, 1, 32'h404, 32'h99, 32'h9, 1, 0);
    check_output("mid_rst_occ", occupancy, 0);
    check_output("mid_rst_inst", out_inst, 32'h13);
    check_output("mid_rst_stall", stall_cnt, 0);
    check_output("mid_rst_valid", out_valid, 0);
    check_output("mid_rst_in_ready", in_ready, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0);
    check_output("after_rst_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter PC_W, default 32, width of the PC payload field.
REQ-002 Parameter INST_W, default 32, width of the instruction payload field.
REQ-003 Parameter SIDE_W, default 32, width of the opaque sideband field (e.g. auxiliary PC address).
REQ-004 Parameter NOP_INST, default 32'h00000013 (addi x0,x0,0), instruction value presented when the stage holds no valid entry.
REQ-005 Parameter CNT_W, default 16, width of the stall counter.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-008 flush  input  1  kill all held entries and the incoming beat this cycle.
REQ-009 in_valid  input  1  upstream beat present.
REQ-010 in_ready  output  1  stage can accept a beat this cycle.
REQ-011 in_pc / in_inst / in_side  input  PC_W / INST_W / SIDE_W  upstream payload.
REQ-012 out_valid  output  1  downstream beat present.
REQ-013 out_ready  input  1  downstream accepts the beat.
REQ-014 out_pc / out_inst / out_side  output  PC_W / INST_W / SIDE_W  downstream payload.
REQ-015 occupancy  output  2  number of held entries (0, 1, 2).
REQ-016 stall_clr  input  1  clear stall counter.
REQ-017 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Storage SHALL be two payload entries: main (drives outputs) and skid.
REQ-019 States SHALL be EMPTY (0 entries), ONE (main valid), FULL (main+skid valid); occupancy SHALL equal 0/1/2 respectively.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, derived from state registers only (no combinational path from out_ready or in_valid).
REQ-021 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-022 Input accept = in_valid & in_ready; output accept = out_valid & out_ready.
REQ-023 EMPTY: input accept -> ONE, main <= input; else stay.
REQ-024 ONE: input and output accept -> ONE, main <= input; input only -> FULL, skid <= input; output only -> EMPTY; neither -> stay.
REQ-025 FULL: output accept -> ONE, main <= skid; else stay, both entries held unchanged.
REQ-026 Latency SHALL be 1 cycle: a beat accepted at edge N appears on outputs after edge N when the stage was EMPTY or main was simultaneously drained.
REQ-027 Ordering SHALL be strict FIFO; no beat duplicated or dropped except by flush.
REQ-028 When main is not valid, out_pc=0, out_inst=NOP_INST, out_side=0 (main cleared on transition to EMPTY).
REQ-029 flush=1 SHALL force next state EMPTY, clear main to {0, NOP_INST, 0}, discard skid and the same-cycle input beat; flush has priority over all handshake events.
REQ-030 A beat with in_valid=1 during flush SHALL not be considered accepted; upstream must not retire it.
REQ-031 stall_cnt SHALL increment by 1 per cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1 (no wrap).
REQ-032 stall_clr=1 SHALL set stall_cnt to 0 next cycle, overriding a same-cycle increment; flush SHALL not affect stall_cnt.

Reset
REQ-033 rst=0 at a rising edge SHALL set state EMPTY, occupancy 0, main = {0, NOP_INST, 0}, skid = 0, stall_cnt 0; after that edge in_ready=1, out_valid=0.
REQ-034 Reset SHALL override flush, handshake and stall_clr, including mid-FULL; held entries are lost.
REQ-035 Deasserting rst SHALL not by itself create a beat; first beat requires in_valid.

Verification
REQ-036 Reset, then in_valid=1 pc=0x100 inst=0x00500093 with out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_inst=0x00500093, occupancy 1.
REQ-037 out_ready=0, push pc=0x200 then 0x204 -> occupancy 2, in_ready=0, out_pc=0x200; raise out_ready -> 0x200 then 0x204 out in order, occupancy 2->1->0.
REQ-038 FULL state, flush=1 with in_valid=1 pc=0x300 -> next cycle occupancy 0, out_valid=0, out_inst=0x00000013, out_pc=0; 0x300 never appears.
REQ-039 Streaming: in_valid=out_ready=1 for 8 cycles, pcs 0x0..0x1C -> output same sequence, one per cycle, in_ready stays 1, stall_cnt 0.
REQ-040 CNT_W=4, hold out_valid=1 out_ready=0 for 20 cycles -> stall_cnt saturates at 15; stall_clr=1 same cycle as a stall -> stall_cnt 0.
REQ-041 rst=0 asserted while FULL with out_ready=1 -> next cycle occupancy 0, out_inst=0x00000013, stall_cnt 0.
